// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Video-RAM responder between the VDP fetch path, the CPU bus bridge and a
//   single-port synchronous RAM with one cycle of read latency.
//   The VDP owns two fixed dot slots per 8-dot character cell. Every other
//   slot is available to the CPU, whose requests wait in a small FIFO. Video
//   fetch never stalls. The CPU only ever sees back-pressure through ready.
//
// Ports
//   dot_clk          in   sole clock, rising edge
//   reset            in   asynchronous, active-low reset
//   dot[2:0]         in   dot index within the character cell
//   vdp_addr[15:0]   in   VDP fetch address
//   vdp_data[7:0]    out  last VDP fetch result, held between fetches
//   cpu_req_*        in   CPU request: valid, we, addr[15:0], wdata[7:0]
//   cpu_req_ready    out  request accepted in a cycle where valid & ready
//   cpu_rdata[7:0]   out  CPU read result, held
//   cpu_rdata_valid  out  one-cycle pulse when cpu_rdata carries a new result
//   fifo_level[2:0]  out  number of queued CPU requests
//   mem_addr/wdata/we out RAM request for the current cycle
//   mem_rdata[7:0]   in   RAM read data, valid the cycle after the address
//
// Handshake: a CPU request transfers on any rising edge where cpu_req_valid
// and cpu_req_ready are both high. Ready depends only on the FIFO level at
// the start of the cycle. It is low whenever the FIFO is full, even if an
// entry pops in that same cycle.

module vram_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int VDP_SLOT_A = 0,
  parameter int VDP_SLOT_B = 4
) (
  input  logic        dot_clk,
  input  logic        reset,
  input  logic [2:0]  dot,
  input  logic [15:0] vdp_addr,
  output logic [7:0]  vdp_data,
  input  logic        cpu_req_valid,
  input  logic        cpu_req_we,
  input  logic [15:0] cpu_req_addr,
  input  logic [7:0]  cpu_req_wdata,
  output logic        cpu_req_ready,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdata_valid,
  output logic [2:0]  fifo_level,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Kind of access presented to the RAM in the previous cycle. It decides
  // which register captures mem_rdata in the current cycle.
  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_VDP    = 2'd1,
    TAG_CPU_RD = 2'd2
  } tag_t;

  logic             fifo_we    [FIFO_DEPTH];
  logic [15:0]      fifo_addr  [FIFO_DEPTH];
  logic [7:0]       fifo_wdata [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [2:0]       level;
  tag_t             tag;

  logic vdp_slot;
  logic cpu_issue;
  logic push;

  assign vdp_slot      = (dot == 3'(VDP_SLOT_A)) || (dot == 3'(VDP_SLOT_B));
  assign cpu_issue     = !vdp_slot && (level != 3'd0);
  assign cpu_req_ready = (level != 3'(FIFO_DEPTH));
  assign push          = cpu_req_valid && cpu_req_ready;
  assign fifo_level    = level;

  // In idle slots the VDP address stays on the bus. This is a harmless read
  // whose result is never captured.
  always_comb begin
    mem_addr  = vdp_addr;
    mem_wdata = 8'h00;
    mem_we    = 1'b0;
    if (cpu_issue) begin
      mem_addr  = fifo_addr[rd_ptr];
      mem_wdata = fifo_wdata[rd_ptr];
      mem_we    = fifo_we[rd_ptr] && reset;
    end
  end

  // Queue storage carries no reset. Only the pointers and level give it
  // meaning.
  always_ff @(posedge dot_clk) begin
    if (push) begin
      fifo_we[wr_ptr]    <= cpu_req_we;
      fifo_addr[wr_ptr]  <= cpu_req_addr;
      fifo_wdata[wr_ptr] <= cpu_req_wdata;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two. A push
  // and a pop in the same cycle leave the level unchanged.
  always_ff @(posedge dot_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= 3'd0;
    end else begin
      if (push)      wr_ptr <= wr_ptr + PTR_W'(1);
      if (cpu_issue) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, cpu_issue})
        2'b10:   level <= level + 3'd1;
        2'b01:   level <= level - 3'd1;
        default: level <= level;
      endcase
    end
  end

  // Two-stage return path. The tag records the slot type at the issue
  // cycle. The following cycle captures mem_rdata under that tag, so the
  // result becomes visible one cycle later.
  always_ff @(posedge dot_clk or negedge reset) begin
    if (!reset) begin
      tag             <= TAG_NONE;
      vdp_data        <= 8'h00;
      cpu_rdata       <= 8'h00;
      cpu_rdata_valid <= 1'b0;
    end else begin
      if (vdp_slot)
        tag <= TAG_VDP;
      else if (cpu_issue && !fifo_we[rd_ptr])
        tag <= TAG_CPU_RD;
      else
        tag <= TAG_NONE;

      cpu_rdata_valid <= (tag == TAG_CPU_RD);
      if (tag == TAG_VDP)    vdp_data  <= mem_rdata;
      if (tag == TAG_CPU_RD) cpu_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
//   Directed scenarios followed by randomized traffic for vram_arbiter.
//   A behavioural model tracks the request queue, the RAM contents and the
//   due cycle of every read result. It predicts the DUT outputs every cycle.

module tb_vram_arbiter;

  localparam int DEPTH = 4;

  // ---------------------------------------------------------------- clock/reset
  logic        dot_clk = 1'b0;
  logic        reset;
  logic [2:0]  dot;
  logic [15:0] vdp_addr;
  logic [7:0]  vdp_data;
  logic        cpu_req_valid;
  logic        cpu_req_we;
  logic [15:0] cpu_req_addr;
  logic [7:0]  cpu_req_wdata;
  logic        cpu_req_ready;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdata_valid;
  logic [2:0]  fifo_level;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  always #5 dot_clk = ~dot_clk;

  vram_arbiter #(.FIFO_DEPTH(DEPTH), .VDP_SLOT_A(0), .VDP_SLOT_B(4)) dut (
    .dot_clk(dot_clk), .reset(reset), .dot(dot), .vdp_addr(vdp_addr),
    .vdp_data(vdp_data), .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_req_ready(cpu_req_ready), .cpu_rdata(cpu_rdata),
    .cpu_rdata_valid(cpu_rdata_valid), .fifo_level(fifo_level),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    if (a == 16'h1234) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // Single-port synchronous RAM. It loads its initial image on the first
  // edge, which falls inside the reset window.
  logic [7:0] ram [65536];
  logic       ram_loaded = 1'b0;
  always @(posedge dot_clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 65536; i++) ram[i] <= init_byte(16'(i));
      ram_loaded <= 1'b1;
      mem_rdata  <= 8'h00;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  // ---------------------------------------------------------------- model state
  typedef struct { logic we; logic [15:0] addr; logic [7:0] wdata; } req_t;
  typedef struct { int cyc; logic is_vdp; logic [7:0] val; } ev_t;

  req_t       mq[$];        // requests the DUT should be holding, oldest first
  ev_t        ev_q[$];      // read results with the cycle they become visible
  logic [7:0] exp_q[$];     // expected CPU read data, in issue order
  logic [7:0] ref_mem [65536];
  logic [7:0] exp_vdp;
  logic [7:0] exp_rd;
  int         cyc;
  int         n_pass;
  int         n_total;
  logic [2:0] ph;
  logic [15:0] cur_va;

  // ---------------------------------------------------------------- scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    ev_q.delete();
    exp_q.delete();
    exp_vdp = 8'h00;
    exp_rd  = 8'h00;
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_level"}, 32'(fifo_level), 32'd0);
    check({tag, "_ready"}, 32'(cpu_req_ready), 32'd1);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_rvalid"}, 32'(cpu_rdata_valid), 32'd0);
    check({tag, "_rdata"}, 32'(cpu_rdata), 32'd0);
    check({tag, "_vdp"}, 32'(vdp_data), 32'd0);
  endtask

  // ---------------------------------------------------------------- driver
  // Enter and leave 1 time unit after a rising edge. The task applies the
  // inputs, checks every output against the model mid-cycle, then advances
  // the model across the edge.
  task automatic cycle(input logic v, input logic we, input logic [15:0] a,
                       input logic [7:0] wd, input logic [2:0] d,
                       input logic [15:0] va, output logic accepted);
    req_t        h;
    ev_t         e;
    logic        exp_rv;
    logic        vslot;
    logic        issue;
    logic        exp_we;
    logic [15:0] exp_addr;
    int          k;

    cpu_req_valid = v;
    cpu_req_we    = we;
    cpu_req_addr  = a;
    cpu_req_wdata = wd;
    dot           = d;
    vdp_addr      = va;
    #3;

    exp_rv = 1'b0;
    k = 0;
    while (k < ev_q.size()) begin
      if (ev_q[k].cyc == cyc) begin
        if (ev_q[k].is_vdp) exp_vdp = ev_q[k].val;
        else                exp_rv  = 1'b1;
        ev_q.delete(k);
      end else begin
        k++;
      end
    end
    if (exp_rv && exp_q.size() != 0) exp_rd = exp_q.pop_front();

    // Dots 0 and 4 belong to the VDP. Any other dot serves the oldest CPU
    // request, if one is queued.
    vslot    = (d == 3'd0) || (d == 3'd4);
    issue    = !vslot && (mq.size() != 0);
    exp_we   = 1'b0;
    exp_addr = va;
    if (issue) begin
      exp_we   = mq[0].we;
      exp_addr = mq[0].addr;
    end

    check("ready", 32'(cpu_req_ready), 32'(mq.size() < DEPTH));
    check("level", 32'(fifo_level), 32'(mq.size()));
    check("mem_we", 32'(mem_we), 32'(exp_we));
    check("mem_addr", 32'(mem_addr), 32'(exp_addr));
    if (exp_we) check("mem_wdata", 32'(mem_wdata), 32'(mq[0].wdata));
    check("rdata_valid", 32'(cpu_rdata_valid), 32'(exp_rv));
    check("cpu_rdata", 32'(cpu_rdata), 32'(exp_rd));
    check("vdp_data", 32'(vdp_data), 32'(exp_vdp));

    accepted = v && (mq.size() < DEPTH);
    if (vslot) begin
      e.cyc = cyc + 2; e.is_vdp = 1'b1; e.val = ref_mem[va];
      ev_q.push_back(e);
    end
    if (issue) begin
      h = mq.pop_front();
      if (h.we) begin
        ref_mem[h.addr] = h.wdata;
      end else begin
        e.cyc = cyc + 2; e.is_vdp = 1'b0; e.val = 8'h00;
        ev_q.push_back(e);
        exp_q.push_back(ref_mem[h.addr]);
      end
    end
    if (accepted) begin
      h.we = we; h.addr = a; h.wdata = wd;
      mq.push_back(h);
    end
    cyc++;
    @(posedge dot_clk);
    #1;
  endtask

  task automatic step(input logic v, input logic we, input logic [15:0] a, input logic [7:0] wd);
    logic acc;
    cycle(v, we, a, wd, ph, cur_va, acc);
    ph = ph + 3'd1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic align(input logic [2:0] target);
    for (int i = 0; i < 8 && ph != target; i++) step(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic acc;
    logic [2:0] d;
    int tries;

    n_pass = 0; n_total = 0; cyc = 0; ph = 3'd1; cur_va = 16'h0010;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));
    model_clear();

    // Reset held low while the CPU offers a request. Nothing may be queued.
    reset = 1'b0;
    cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_addr = 16'h0200;
    cpu_req_wdata = 8'h77; dot = 3'd1; vdp_addr = 16'h0010;
    repeat (3) @(posedge dot_clk);
    #1;
    reset_check("reset");
    reset = 1'b1;
    idle(4);

    // VDP fetch at dot 0. The result is visible two cycles later and held.
    align(3'd0);
    cur_va = 16'h1234;
    step(1'b0, 1'b0, 16'h0000, 8'h00);
    cur_va = 16'h0010;
    idle(3);
    check("vdp_hold", 32'(vdp_data), 32'h0000_00A5);

    // CPU write, then a read of the same address.
    align(3'd1);
    step(1'b1, 1'b1, 16'h0100, 8'h55);
    step(1'b1, 1'b0, 16'h0100, 8'h00);
    idle(6);
    check("wr_rd_data", 32'(cpu_rdata), 32'h0000_0055);

    // Write pushed at dot 3 must skip the VDP slot at dot 4.
    align(3'd3);
    step(1'b1, 1'b1, 16'h0180, 8'h66);
    idle(6);

    // Fill the FIFO while the dot is held on a VDP slot. The fifth request
    // waits for a pop, and it is not accepted in the full cycle that pops.
    cycle(1'b1, 1'b1, 16'h0300, 8'h11, 3'd0, cur_va, acc);
    cycle(1'b1, 1'b0, 16'h0300, 8'h00, 3'd0, cur_va, acc);
    cycle(1'b1, 1'b1, 16'h0301, 8'h22, 3'd0, cur_va, acc);
    cycle(1'b1, 1'b0, 16'h0301, 8'h00, 3'd0, cur_va, acc);
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_ready", 32'(cpu_req_ready), 32'd0);
    d = 3'd0; acc = 1'b0; tries = 0;
    while (!acc && tries < 10) begin
      cycle(1'b1, 1'b0, 16'h0100, 8'h00, d, cur_va, acc);
      d = d + 3'd1;
      tries++;
    end
    check("fifth_accept_after", 32'(tries), 32'd3);
    ph = d;
    idle(16);

    // Randomized traffic over a small address window so reads hit earlier
    // writes. The dot occasionally jumps.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) ph = 3'($urandom_range(0, 7));
      cur_va = 16'h0040 + 16'($urandom_range(0, 15));
      step($urandom_range(0, 99) < 55, 1'($urandom_range(0, 1)),
           16'h0040 + 16'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end
    cur_va = 16'h0010;
    idle(20);

    // Asynchronous reset in the middle of a drain. A read is in flight.
    cycle(1'b1, 1'b0, 16'h0300, 8'h00, 3'd0, cur_va, acc);
    cycle(1'b1, 1'b1, 16'h0302, 8'h33, 3'd0, cur_va, acc);
    cycle(1'b1, 1'b0, 16'h0301, 8'h00, 3'd0, cur_va, acc);
    cycle(1'b1, 1'b1, 16'h0303, 8'h44, 3'd0, cur_va, acc);
    cycle(1'b0, 1'b0, 16'h0000, 8'h00, 3'd1, cur_va, acc);
    check("pre_reset_level", 32'(fifo_level), 32'd3);
    cpu_req_valid = 1'b0;
    dot = 3'd2;
    #2;
    reset = 1'b0;
    #1;
    reset_check("mid_reset");
    model_clear();
    @(posedge dot_clk);
    #1;
    reset_check("mid_reset_held");
    reset = 1'b1;
    ph = 3'd3;
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
